pic_interrupt_sequencer: RTL and testbench

- Sequencing and priority-management controller for the 8259-style PIC core.
- Each cycle it compares unmasked pending requests against the in-service set and raises INT when a request outranks every in-service level.
- Runs the two-pulse INTA acknowledge sequence, maintains the ISR and the rotating 3-bit priority table, and handles EOI and rotation commands.
- Sits between the IRR/IMR register block and the data-bus/vector logic.

---
 rtl/pic_pkg.sv | 42 ++++
 rtl/pic_prio_select.sv | 34 +++
 rtl/pic_interrupt_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants, FSM state type and priority-table helpers for the PIC
// interrupt sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR      = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned SPURIOUS_ID = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK1,
    ST_WAIT_ACK2
  } pic_state_e;

  // Entry i holds the 3-bit priority of IR i; larger value = higher priority.
  typedef logic [NUM_IR-1:0][ID_W-1:0] prio_tbl_t;

  function automatic prio_tbl_t reset_prio();
    prio_tbl_t r;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      r[i] = ID_W'(NUM_IR - 1 - i);
    end
    return r;
  endfunction

  // Rotate so that level lvl becomes priority 0; 3-bit subtraction wraps mod 8.
  function automatic prio_tbl_t rotate_prio(input prio_tbl_t tbl, input logic [ID_W-1:0] lvl);
    prio_tbl_t r;
    for (int unsigned j = 0; j < NUM_IR; j++) begin
      r[j] = tbl[j] - tbl[lvl];
    end
    return r;
  endfunction

  function automatic logic [NUM_IR-1:0] id_to_mask(input logic [ID_W-1:0] id);
    logic [NUM_IR-1:0] m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pic_prio_select.sv
// Combinational selector: returns the set bit of i_vec whose entry in the
// priority table is largest, along with that priority.
module pic_prio_select
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] i_vec,
  input  prio_tbl_t         i_prio,
  output logic              o_found_c,
  output logic [ID_W-1:0]   o_id_c,
  output logic [ID_W-1:0]   o_prio_c
);

  logic            w_found;
  logic [ID_W-1:0] w_id;
  logic [ID_W-1:0] w_prio;

  always_comb begin
    w_found = 1'b0;
    w_id    = '0;
    w_prio  = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (i_vec[i] && (!w_found || (i_prio[i] > w_prio))) begin
        w_found = 1'b1;
        w_id    = ID_W'(i);
        w_prio  = i_prio[i];
      end
    end
  end

  assign o_found_c = w_found;
  assign o_id_c    = w_id;
  assign o_prio_c  = w_prio;

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259-style sequencing core: nested-priority INT generation, two-pulse INTA
// acknowledge, ISR maintenance, EOI handling and priority rotation.
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic              inta,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [ID_W-1:0]   eoi_level,
  input  logic              eoi_rotate,
  input  logic              set_prio,
  input  logic              auto_eoi,
  output logic              int_req,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] irr_clear,
  output logic              vector_valid,
  output logic [ID_W-1:0]   vector_id,
  output logic              spurious,
  output logic [NUM_IR-1:0] prio_p1,
  output logic [NUM_IR-1:0] prio_p2,
  output logic [NUM_IR-1:0] prio_p3
);

  pic_state_e        r_state, w_state_nxt;
  prio_tbl_t         r_prio, w_prio_nxt;
  logic [NUM_IR-1:0] r_isr, w_isr_nxt;
  logic [NUM_IR-1:0] r_irr_clear, w_irr_clear_nxt;
  logic              r_int_req, w_int_req_nxt;
  logic              r_vector_valid, w_vector_valid_nxt;
  logic [ID_W-1:0]   r_vector_id, w_vector_id_nxt;
  logic              r_spurious, w_spurious_nxt;
  logic [ID_W-1:0]   r_ack_id, w_ack_id_nxt;
  logic              r_spur_lat, w_spur_lat_nxt;

  logic [NUM_IR-1:0] w_pend;
  logic              w_win_found, w_isr_found, w_win_ok;
  logic [ID_W-1:0]   w_win_id, w_win_prio, w_isr_id, w_isr_prio;
  logic [NUM_IR-1:0] w_eoi_clr, w_auto_clr, w_isr_set;
  logic [ID_W-1:0]   w_eoi_lvl;

  assign w_pend = irr & ~imr;

  pic_prio_select u_sel_irr (
    .i_vec     (w_pend),
    .i_prio    (r_prio),
    .o_found_c (w_win_found),
    .o_id_c    (w_win_id),
    .o_prio_c  (w_win_prio)
  );

  pic_prio_select u_sel_isr (
    .i_vec     (r_isr),
    .i_prio    (r_prio),
    .o_found_c (w_isr_found),
    .o_id_c    (w_isr_id),
    .o_prio_c  (w_isr_prio)
  );

  // An empty ISR behaves as priority -1, so any winner passes the nested gate.
  assign w_win_ok = w_win_found && (!w_isr_found || (w_win_prio > w_isr_prio));

  // EOI clear mask and the level it hits, evaluated on the pre-update ISR.
  always_comb begin
    w_eoi_clr = '0;
    w_eoi_lvl = eoi_level;
    if (eoi_valid) begin
      if (eoi_specific) begin
        w_eoi_clr = r_isr & id_to_mask(eoi_level);
      end else if (w_isr_found) begin
        w_eoi_clr = id_to_mask(w_isr_id);
        w_eoi_lvl = w_isr_id;
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_int_req_nxt      = 1'b0;
    w_irr_clear_nxt    = '0;
    w_vector_valid_nxt = 1'b0;
    w_vector_id_nxt    = r_vector_id;
    w_spurious_nxt     = r_spurious;
    w_ack_id_nxt       = r_ack_id;
    w_spur_lat_nxt     = r_spur_lat;
    w_isr_set          = '0;
    w_auto_clr         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_ok) begin
          w_state_nxt   = ST_WAIT_ACK1;
          w_int_req_nxt = 1'b1;
        end
      end
      ST_WAIT_ACK1: begin
        w_int_req_nxt = 1'b1;
        if (inta) begin
          w_int_req_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_ACK2;
          if (w_win_ok) begin
            w_ack_id_nxt    = w_win_id;
            w_isr_set       = id_to_mask(w_win_id);
            w_irr_clear_nxt = id_to_mask(w_win_id);
            w_spur_lat_nxt  = 1'b0;
          end else begin
            w_ack_id_nxt   = ID_W'(SPURIOUS_ID);
            w_spur_lat_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_ACK2: begin
        if (inta) begin
          w_vector_valid_nxt = 1'b1;
          w_vector_id_nxt    = r_ack_id;
          w_spurious_nxt     = r_spur_lat;
          if (auto_eoi && !r_spur_lat) begin
            w_auto_clr = id_to_mask(r_ack_id);
          end
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Set beats clear on the same bit; an EOI-induced rotation overrides set_prio.
  always_comb begin
    w_isr_nxt  = (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_isr_set;
    w_prio_nxt = r_prio;
    if (eoi_rotate && (|w_eoi_clr)) begin
      w_prio_nxt = rotate_prio(r_prio, w_eoi_lvl);
    end else if (set_prio) begin
      w_prio_nxt = rotate_prio(r_prio, eoi_level);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_prio         <= reset_prio();
      r_isr          <= '0;
      r_irr_clear    <= '0;
      r_int_req      <= 1'b0;
      r_vector_valid <= 1'b0;
      r_vector_id    <= '0;
      r_spurious     <= 1'b0;
      r_ack_id       <= '0;
      r_spur_lat     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_prio         <= w_prio_nxt;
      r_isr          <= w_isr_nxt;
      r_irr_clear    <= w_irr_clear_nxt;
      r_int_req      <= w_int_req_nxt;
      r_vector_valid <= w_vector_valid_nxt;
      r_vector_id    <= w_vector_id_nxt;
      r_spurious     <= w_spurious_nxt;
      r_ack_id       <= w_ack_id_nxt;
      r_spur_lat     <= w_spur_lat_nxt;
    end
  end

  assign int_req      = r_int_req;
  assign isr          = r_isr;
  assign irr_clear    = r_irr_clear;
  assign vector_valid = r_vector_valid;
  assign vector_id    = r_vector_id;
  assign spurious     = r_spurious;

  for (genvar g = 0; g < NUM_IR; g++) begin : g_planes
    assign prio_p1[g] = r_prio[g][2];
    assign prio_p2[g] = r_prio[g][1];
    assign prio_p3[g] = r_prio[g][0];
  end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Self-checking bench for pic_interrupt_sequencer: directed scenarios plus a
// randomized run against a behavioural priority/ISR model.
module tb_pic_interrupt_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] irr, imr;
  logic       inta, eoi_valid, eoi_specific, eoi_rotate, set_prio, auto_eoi;
  logic [2:0] eoi_level;
  logic       int_req, vector_valid, spurious;
  logic [7:0] isr, irr_clear, prio_p1, prio_p2, prio_p3;
  logic [2:0] vector_id;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural reference state
  int         m_prio[8];
  logic [7:0] m_isr, m_irr_clear;
  logic       m_int_req, m_vv, m_sp, m_spl;
  int         m_vid, m_ack, m_phase;

  pic_interrupt_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .irr          (irr),
    .imr          (imr),
    .inta         (inta),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .eoi_rotate   (eoi_rotate),
    .set_prio     (set_prio),
    .auto_eoi     (auto_eoi),
    .int_req      (int_req),
    .isr          (isr),
    .irr_clear    (irr_clear),
    .vector_valid (vector_valid),
    .vector_id    (vector_id),
    .spurious     (spurious),
    .prio_p1      (prio_p1),
    .prio_p2      (prio_p2),
    .prio_p3      (prio_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_prio[i] = 7 - i;
    m_isr = '0; m_irr_clear = '0;
    m_int_req = 1'b0; m_vv = 1'b0; m_sp = 1'b0; m_spl = 1'b0;
    m_vid = 0; m_ack = 0; m_phase = 0;
  endtask

  function automatic logic [7:0] m_plane(input int b);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ((m_prio[i] >> b) & 1) != 0;
    return p;
  endfunction

  task automatic rotate_model(input int lvl);
    int pl;
    pl = m_prio[lvl];
    for (int j = 0; j < 8; j++) m_prio[j] = (m_prio[j] - pl + 8) % 8;
  endtask

  // One clock of the reference, driven by the inputs currently applied.
  task automatic model_step();
    logic [7:0] pend, clr, set;
    int best, wid, imax, iid, lvl;
    logic win_ok;
    if (reset) begin
      model_reset();
      return;
    end
    pend = irr & ~imr;
    best = -1; wid = 0; imax = -1; iid = -1;
    for (int i = 0; i < 8; i++) begin
      if (pend[i] && m_prio[i] > best) begin best = m_prio[i]; wid = i; end
      if (m_isr[i] && m_prio[i] > imax) begin imax = m_prio[i]; iid = i; end
    end
    win_ok = best > imax;
    clr = '0; set = '0; lvl = -1;
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (m_isr[eoi_level]) begin clr[eoi_level] = 1'b1; lvl = int'(eoi_level); end
      end else if (iid >= 0) begin
        clr[iid] = 1'b1; lvl = iid;
      end
    end
    m_vv = 1'b0; m_irr_clear = '0; m_int_req = 1'b0;
    if (m_phase == 0) begin
      if (win_ok) begin m_phase = 1; m_int_req = 1'b1; end
    end else if (m_phase == 1) begin
      m_int_req = 1'b1;
      if (inta) begin
        m_int_req = 1'b0; m_phase = 2;
        if (win_ok) begin m_ack = wid; set[wid] = 1'b1; m_irr_clear[wid] = 1'b1; m_spl = 1'b0; end
        else begin m_ack = 7; m_spl = 1'b1; end
      end
    end else if (inta) begin
      m_vv = 1'b1; m_vid = m_ack; m_sp = m_spl;
      if (auto_eoi && !m_spl) clr[m_ack] = 1'b1;
      m_phase = 0;
    end
    if (eoi_rotate && lvl >= 0) rotate_model(lvl);
    else if (set_prio) rotate_model(int'(eoi_level));
    m_isr = (m_isr & ~clr) | set;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    inta = 0; eoi_valid = 0; eoi_specific = 0; eoi_rotate = 0; set_prio = 0; eoi_level = 0;
  endtask

  // Drives a full two-INTA acknowledge of req, dropping irr after the first INTA.
  task automatic run_ack(input logic [7:0] req);
    irr = req; step();
    inta = 1; step();
    inta = 0; irr = 0; step();
    inta = 1; step();
    inta = 0;
  endtask

  task automatic test_reset();
    reset = 1; irr = 0; imr = 0; auto_eoi = 0; clear_cmds();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({int_req, isr, irr_clear, vector_valid, vector_id, spurious} !== 21'd0) begin
      n_mis++; $display("FAIL reset_outputs: got %h want 0", {int_req, isr, irr_clear, vector_valid, vector_id, spurious}); end
    n_cmp++; if ({prio_p1, prio_p2, prio_p3} !== 24'h0F3355) begin
      n_mis++; $display("FAIL reset_prio: got %h want 0f3355", {prio_p1, prio_p2, prio_p3}); end
    reset = 0; step();
  endtask

  task automatic test_basic();
    irr = 8'h05; step();
    n_cmp++; if (int_req !== 1'b1) begin n_mis++; $display("FAIL basic_int_req: got %b want 1", int_req); end
    inta = 1; step(); inta = 0;
    n_cmp++; if (isr !== 8'h01) begin n_mis++; $display("FAIL basic_isr: got %h want 01", isr); end
    n_cmp++; if (irr_clear !== 8'h01) begin n_mis++; $display("FAIL basic_irr_clear: got %h want 01", irr_clear); end
    n_cmp++; if (int_req !== 1'b0) begin n_mis++; $display("FAIL basic_int_drop: got %b want 0", int_req); end
    irr = 8'h04; step();
    n_cmp++; if (irr_clear !== 8'h00) begin n_mis++; $display("FAIL basic_irr_clear_pulse: got %h want 00", irr_clear); end
    inta = 1; step(); inta = 0;
    n_cmp++; if ({vector_valid, vector_id, spurious} !== 5'b1_000_0) begin
      n_mis++; $display("FAIL basic_vector: got %b want 10000", {vector_valid, vector_id, spurious}); end
    step();
    n_cmp++; if ({vector_valid, vector_id} !== 4'b0_000) begin
      n_mis++; $display("FAIL basic_vector_hold: got %b want 0000", {vector_valid, vector_id}); end
    irr = 0; eoi_valid = 1; step(); clear_cmds();
    n_cmp++; if (isr !== 8'h00) begin n_mis++; $display("FAIL basic_eoi: got %h want 00", isr); end
  endtask

  task automatic test_nested();
    run_ack(8'h08); step();
    irr = 8'h20; repeat (3) step();
    n_cmp++; if ({int_req, isr} !== 9'h008) begin n_mis++; $display("FAIL nested_blocked: got %h want 008", {int_req, isr}); end
    irr = 8'h22; step();
    n_cmp++; if (int_req !== 1'b1) begin n_mis++; $display("FAIL nested_int_req: got %b want 1", int_req); end
    inta = 1; step(); inta = 0;
    n_cmp++; if (isr !== 8'h0A) begin n_mis++; $display("FAIL nested_isr: got %h want 0a", isr); end
    irr = 8'h20; step();
    inta = 1; step(); inta = 0;
    n_cmp++; if ({vector_valid, vector_id} !== 4'b1_001) begin
      n_mis++; $display("FAIL nested_vector: got %b want 1001", {vector_valid, vector_id}); end
    irr = 0; eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd1; step();
    eoi_level = 3'd3; step(); clear_cmds();
    n_cmp++; if (isr !== 8'h00) begin n_mis++; $display("FAIL nested_specific_eoi: got %h want 00", isr); end
  endtask

  task automatic test_spurious();
    irr = 8'h10; step();
    n_cmp++; if (int_req !== 1'b1) begin n_mis++; $display("FAIL spur_int_req: got %b want 1", int_req); end
    irr = 0; inta = 1; step(); inta = 0;
    n_cmp++; if ({isr, irr_clear} !== 16'h0000) begin n_mis++; $display("FAIL spur_no_ack: got %h want 0000", {isr, irr_clear}); end
    step(); inta = 1; step(); inta = 0;
    n_cmp++; if ({vector_valid, vector_id, spurious} !== 5'b1_111_1) begin
      n_mis++; $display("FAIL spur_vector: got %b want 11111", {vector_valid, vector_id, spurious}); end
  endtask

  task automatic test_rotate();
    run_ack(8'h04); step();
    n_cmp++; if (isr !== 8'h04) begin n_mis++; $display("FAIL rot_isr_set: got %h want 04", isr); end
    eoi_valid = 1; eoi_rotate = 1; step(); clear_cmds();
    n_cmp++; if (isr !== 8'h00) begin n_mis++; $display("FAIL rot_isr_clear: got %h want 00", isr); end
    n_cmp++; if ({prio_p1[2], prio_p2[2], prio_p3[2], prio_p1[3], prio_p2[3], prio_p3[3], prio_p1[1], prio_p2[1], prio_p3[1]}
                 !== 9'b000_111_001) begin
      n_mis++; $display("FAIL rot_prio: got %b want 000111001",
        {prio_p1[2], prio_p2[2], prio_p3[2], prio_p1[3], prio_p2[3], prio_p3[3], prio_p1[1], prio_p2[1], prio_p3[1]}); end
    irr = 8'h0A; step();
    inta = 1; step(); inta = 0;
    n_cmp++; if (isr !== 8'h08) begin n_mis++; $display("FAIL rot_winner_isr: got %h want 08", isr); end
    irr = 0; step(); inta = 1; step(); inta = 0;
    n_cmp++; if (vector_id !== 3'd3) begin n_mis++; $display("FAIL rot_winner_id: got %0d want 3", vector_id); end
    eoi_valid = 1; step(); clear_cmds();
  endtask

  task automatic test_auto_eoi();
    auto_eoi = 1; run_ack(8'h40);
    n_cmp++; if ({vector_valid, vector_id, isr} !== 12'hE00) begin
      n_mis++; $display("FAIL aeoi_vector_isr: got %h want e00", {vector_valid, vector_id, isr}); end
    auto_eoi = 0; set_prio = 1; eoi_level = 3'd7; step(); clear_cmds();
    n_cmp++; if ({prio_p1, prio_p2, prio_p3} !== 24'h0F3355) begin
      n_mis++; $display("FAIL setprio_restore: got %h want 0f3355", {prio_p1, prio_p2, prio_p3}); end
  endtask

  task automatic test_reset_mid();
    set_prio = 1; eoi_level = 3'd0; step(); clear_cmds();
    irr = 8'h02; step();
    inta = 1; step(); inta = 0; irr = 0; step();
    reset = 1; #1;
    n_cmp++; if ({int_req, isr, irr_clear, vector_valid, vector_id, spurious} !== 21'd0) begin
      n_mis++; $display("FAIL midreset_outputs: got %h want 0", {int_req, isr, irr_clear, vector_valid, vector_id, spurious}); end
    n_cmp++; if ({prio_p1, prio_p2, prio_p3} !== 24'h0F3355) begin
      n_mis++; $display("FAIL midreset_prio: got %h want 0f3355", {prio_p1, prio_p2, prio_p3}); end
    inta = 1; step(); inta = 0; reset = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (vector_valid !== 1'b0) begin n_mis++; $display("FAIL midreset_no_vector: got %b want 0", vector_valid); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      irr = 8'($urandom);
      imr = 8'($urandom & $urandom);
      inta = ($urandom_range(0, 3) == 0);
      eoi_valid = ($urandom_range(0, 5) == 0);
      eoi_specific = 1'($urandom);
      eoi_rotate = 1'($urandom);
      eoi_level = 3'($urandom);
      set_prio = ($urandom_range(0, 9) == 0);
      if (c % 50 == 0) auto_eoi = 1'($urandom);
      step();
      n_cmp++; if ({int_req, isr, irr_clear, vector_valid, vector_id, spurious} !==
                   {m_int_req, m_isr, m_irr_clear, m_vv, 3'(m_vid), m_sp}) begin
        n_mis++; $display("FAIL rand_outputs cycle %0d: got %h want %h", c,
          {int_req, isr, irr_clear, vector_valid, vector_id, spurious},
          {m_int_req, m_isr, m_irr_clear, m_vv, 3'(m_vid), m_sp}); end
      n_cmp++; if ({prio_p1, prio_p2, prio_p3} !== {m_plane(2), m_plane(1), m_plane(0)}) begin
        n_mis++; $display("FAIL rand_prio cycle %0d: got %h want %h", c,
          {prio_p1, prio_p2, prio_p3}, {m_plane(2), m_plane(1), m_plane(0)}); end
    end
    clear_cmds(); irr = 0; imr = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_spurious();
    test_rotate();
    test_auto_eoi();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
